mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Parametrised load/store unit between the execute stage and a variable-latency data memory. It replaces fixed single-cycle block-RAM access with a request/grant/response handshake. It generates byte-lane enables and lane-replicated store data, and sign/zero-extends and lane-selects load data. It detects misaligned or illegal accesses and holds one transaction in flight, back-pressuring the core via req_ready.

Parameters:
DATA_W, 32, memory/datapath width in bits; legal values 32 or 64
ADDR_W, 32, byte address width
BIG_ENDIAN, 1, 1: byte at lowest address occupies MSB lane; 0: LSB lane
RD_W, 5, destination register index width

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset; asynchronous, active-low
req_valid  in  1  core presents an access
req_ready  out  1  unit can accept (high only in IDLE)
req_we  in  1  1 store, 0 load
req_size  in  2  00 byte, 01 half, 10 word, 11 dword
req_unsigned  in  1  zero-extend load when 1
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-justified
req_rd  in  RD_W  load destination register
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  extended load data; 0 for stores/faults
resp_rd  out  RD_W  destination of completed load
resp_we  out  1  register write strobe (loads without fault only)
resp_misalign  out  1  fault flag, valid with resp_valid
mem_req  out  1  memory request, held until grant
mem_gnt  in  1  memory accepts request this cycle
mem_we  out  1  write request
mem_addr  out  ADDR_W  address with log2(DATA_W/8) LSBs cleared
mem_be  out  DATA_W/8  byte enables
mem_wdata  out  DATA_W  store data replicated across lanes
mem_rvalid  in  1  load data valid
mem_rdata  in  DATA_W  load data

Behaviour:
- Reset (rst low, async): state IDLE; req_ready=1 once released; every other output 0 immediately, including mem_req mid-transaction; in-flight access abandoned and its rvalid is not expected.
- FSM: IDLE -> ISSUE on req_valid&req_ready (legal access); IDLE -> FAULT (illegal); ISSUE -> WAIT on mem_gnt for loads; ISSUE -> DONE on mem_gnt for stores; WAIT -> DONE on mem_rvalid; DONE/FAULT -> IDLE unconditionally.
- Request fields captured at acceptance; mem_* outputs registered, stable from the cycle after acceptance until the grant cycle.
- Illegal: req_size=11 when DATA_W=32; address not aligned to the size (half: addr[0]!=0; word: addr[1:0]!=0; dword: addr[2:0]!=0). Illegal accesses issue no mem_req.
- Lane index L = addr[log2(DATA_W/8)-1:0]. BIG_ENDIAN=1: byte lane L spans bits [DATA_W-1-8L -: 8]; BIG_ENDIAN=0: bits [8L+7 : 8L].
- mem_be: size-wide contiguous run starting at lane L. Example: SB at lane 1 of 32-bit big-endian gives 0100; SH at lane 2 gives 0011.
- Store data: low 8/16/32/64 bits of req_wdata replicated across DATA_W.
- Load: select size bytes at lane L; extend to DATA_W with the sign bit unless req_unsigned. Unsigned dword is the same as signed dword.
- Latency: accept at T0, mem_req at T1. Store: gnt at Tg gives resp_valid at Tg+1. Load: rvalid at Tr (earliest Tg+1) gives resp_valid at Tr+1. Fault: resp_valid at T1.
- mem_rvalid outside WAIT is ignored. mem_gnt outside ISSUE is ignored.
- resp_valid is a single-cycle pulse with no back-pressure. resp_rd equals the captured req_rd. resp_we = load & ~fault.
- req_ready=0 in ISSUE, WAIT, DONE and FAULT. Next acceptance happens at the earliest in the cycle after resp_valid.

Decomposition:
- Shared package mem_pkg: size encodings (SZ_BYTE..SZ_DWORD), state encoding, function lanes_of(DATA_W).
- One sub-module, mem_lane_align: combinational be/wdata generation and load select/extend, parametrised by DATA_W and BIG_ENDIAN.
- The FSM and registers live in the top module.

Test Plan:
- DATA_W=32, BE=1: SB addr 0x1001, wdata 0x000000AB, gnt same cycle as mem_req -> mem_addr 0x1000, mem_be 0100, mem_wdata 0xABABABAB; resp_valid next cycle with resp_we=0.
- LB addr 0x1003, rdata 0x12345680 -> resp_rdata 0xFFFFFF80, resp_we=1. Repeat with LBU -> 0x00000080. LH addr 0x1002 -> 0x00005680.
- LH addr 0x1001 -> no mem_req; resp_valid at T1 with resp_misalign=1, resp_rdata 0, resp_we 0. Dword on DATA_W=32 -> same response.
- Load with gnt delayed 3 cycles and rvalid 2 cycles after gnt -> mem_req/mem_addr stable over 4 cycles, req_ready 0 throughout; resp_valid exactly 1 cycle after rvalid.
- rst pulled low in WAIT -> mem_req and resp_* drop immediately; stray rvalid after release is ignored; the next LW completes normally.
- DATA_W=64, BE=1: SW addr 0x2004, wdata 0xDEADBEEF -> mem_be 0x0F, mem_addr 0x2000. LD addr 0x2000 -> full rdata returned.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM states
// and the lane-count helper used to size byte enables.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    function automatic int lanes_of(input int data_w);
        return data_w / 32'sd8;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store-side byte enables and replicated write data,
// load-side lane select with sign/zero extension. Purely combinational.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1,
    localparam int LANES     = lanes_of(DATA_W),
    localparam int LANE_W    = $clog2(LANES)
) (
    input  logic [1:0]        st_size,
    input  logic [LANE_W-1:0] st_lane,
    input  logic [DATA_W-1:0] st_wdata,
    output logic [LANES-1:0]  st_be,
    output logic [DATA_W-1:0] st_wdata_rep,
    input  logic [1:0]        ld_size,
    input  logic [LANE_W-1:0] ld_lane,
    input  logic              ld_unsigned,
    input  logic [DATA_W-1:0] ld_rdata,
    output logic [DATA_W-1:0] ld_data
);

    logic [3:0]        st_bytes_s;
    logic [6:0]        ld_bits_s;
    logic [DATA_W-1:0] ld_field_s;
    logic              ld_sign_s;

    // Byte enables: a run of size bytes starting at the lane, mapped to bit lanes by endianness
    always_comb begin
        st_be      = '0;
        st_bytes_s = 4'd1 << st_size;
        for (int j = 0; j < LANES; j++) begin
            st_be[BIG_ENDIAN ? (LANES - 1 - j) : j] =
                (j >= int'(st_lane)) && (j < int'(st_lane) + int'(st_bytes_s));
        end
    end

    // Store data: low size bits of the operand repeated across the full bus
    always_comb begin
        st_wdata_rep = '0;
        case (st_size)
            SZ_BYTE: for (int i = 0; i < DATA_W; i++) st_wdata_rep[i] = st_wdata[i % 8];
            SZ_HALF: for (int i = 0; i < DATA_W; i++) st_wdata_rep[i] = st_wdata[i % 16];
            SZ_WORD: for (int i = 0; i < DATA_W; i++) st_wdata_rep[i] = st_wdata[i % 32];
            default: st_wdata_rep = st_wdata;
        endcase
    end

    // Load path: right-justify the addressed bytes, then extend above the access width
    always_comb begin
        ld_bits_s = 7'd8 << ld_size;
        if (BIG_ENDIAN) begin
            ld_field_s = (ld_rdata << {ld_lane, 3'b000}) >> (DATA_W - int'(ld_bits_s));
        end else begin
            ld_field_s = ld_rdata >> {ld_lane, 3'b000};
        end
        case (ld_size)
            SZ_BYTE: ld_sign_s = ld_field_s[7];
            SZ_HALF: ld_sign_s = ld_field_s[15];
            SZ_WORD: ld_sign_s = ld_field_s[31];
            default: ld_sign_s = ld_field_s[DATA_W-1];
        endcase
        ld_sign_s = ld_sign_s & ~ld_unsigned;
        ld_data   = '0;
        for (int i = 0; i < DATA_W; i++) begin
            ld_data[i] = (i < int'(ld_bits_s)) ? ld_field_s[i] : ld_sign_s;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit with one transaction in flight over a request/grant/rvalid
// memory handshake; faults on misaligned or unsupported sizes without touching memory.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int RD_W       = 5,
    localparam int LANES     = lanes_of(DATA_W),
    localparam int LANE_W    = $clog2(LANES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [RD_W-1:0]   req_rd,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [RD_W-1:0]   resp_rd,
    output logic              resp_we,
    output logic              resp_misalign,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LANES-1:0]  mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam bit HAS_DWORD = (DATA_W == 64);

    state_e            state_r;
    logic              we_r;
    logic              uns_r;
    logic [1:0]        size_r;
    logic [LANE_W-1:0] lane_r;
    logic [RD_W-1:0]   rd_r;
    logic              illegal_s;
    logic [LANES-1:0]  be_s;
    logic [DATA_W-1:0] wrep_s;
    logic [DATA_W-1:0] ld_data_s;

    mem_lane_align #(
        .DATA_W     (DATA_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_align (
        .st_size      (req_size),
        .st_lane      (req_addr[LANE_W-1:0]),
        .st_wdata     (req_wdata),
        .st_be        (be_s),
        .st_wdata_rep (wrep_s),
        .ld_size      (size_r),
        .ld_lane      (lane_r),
        .ld_unsigned  (uns_r),
        .ld_rdata     (mem_rdata),
        .ld_data      (ld_data_s)
    );

    // Classify the presented request as unaligned or wider than the bus
    always_comb begin
        case (req_size)
            SZ_BYTE:  illegal_s = 1'b0;
            SZ_HALF:  illegal_s = req_addr[0];
            SZ_WORD:  illegal_s = |req_addr[1:0];
            SZ_DWORD: illegal_s = ~HAS_DWORD | (|req_addr[2:0]);
            default:  illegal_s = 1'b1;
        endcase
    end

    // Transaction FSM; every output is a register so memory sees a clean request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            req_ready     <= 1'b1;
            we_r          <= 1'b0;
            uns_r         <= 1'b0;
            size_r        <= SZ_BYTE;
            lane_r        <= '0;
            rd_r          <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_rd       <= '0;
            resp_we       <= 1'b0;
            resp_misalign <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_be        <= '0;
            mem_wdata     <= '0;
        end else begin
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_rd       <= '0;
            resp_we       <= 1'b0;
            resp_misalign <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        we_r      <= req_we;
                        uns_r     <= req_unsigned;
                        size_r    <= req_size;
                        lane_r    <= req_addr[LANE_W-1:0];
                        rd_r      <= req_rd;
                        if (illegal_s) begin
                            state_r       <= ST_FAULT;
                            resp_valid    <= 1'b1;
                            resp_misalign <= 1'b1;
                            resp_rd       <= req_rd;
                        end else begin
                            state_r   <= ST_ISSUE;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                            mem_be    <= be_s;
                            mem_wdata <= wrep_s;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mem_gnt) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                        if (we_r) begin
                            state_r    <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_rd    <= rd_r;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        state_r    <= ST_DONE;
                        resp_valid <= 1'b1;
                        resp_we    <= 1'b1;
                        resp_rdata <= ld_data_s;
                        resp_rd    <= rd_r;
                    end
                end
                ST_DONE, ST_FAULT: begin
                    state_r   <= ST_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    req_ready <= 1'b1;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit (32- and 64-bit, big-endian)
// against a byte-level reference model of the load/store rules.
module tb_mem_access_unit;

    localparam bit BIGE = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    bit          use64 = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0;
    logic [63:0] req_wdata = 64'h0;
    logic [4:0]  req_rd = 5'd0;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = 64'h0;

    logic        a_ready, a_rv, a_rwe, a_mis, a_mreq, a_mwe;
    logic [31:0] a_rdata, a_maddr, a_mwdata;
    logic [4:0]  a_rd;
    logic [3:0]  a_mbe;
    logic        b_ready, b_rv, b_rwe, b_mis, b_mreq, b_mwe;
    logic [63:0] b_rdata, b_mwdata;
    logic [31:0] b_maddr;
    logic [4:0]  b_rd;
    logic [7:0]  b_mbe;

    int n_vec = 0;
    int n_err = 0;

    bit          r_we, r_uns;
    logic [1:0]  r_sz;
    logic [31:0] r_addr;
    logic [63:0] r_wd, r_rdat;
    logic [4:0]  r_rd;
    int          r_gd, r_rvd;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(BIGE), .RD_W(5)) dut32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && !use64), .req_ready(a_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .req_rd(req_rd),
        .resp_valid(a_rv), .resp_rdata(a_rdata), .resp_rd(a_rd), .resp_we(a_rwe),
        .resp_misalign(a_mis), .mem_req(a_mreq), .mem_gnt(mem_gnt && !use64),
        .mem_we(a_mwe), .mem_addr(a_maddr), .mem_be(a_mbe), .mem_wdata(a_mwdata),
        .mem_rvalid(mem_rvalid && !use64), .mem_rdata(mem_rdata[31:0])
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32), .BIG_ENDIAN(BIGE), .RD_W(5)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && use64), .req_ready(b_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(b_rv), .resp_rdata(b_rdata), .resp_rd(b_rd), .resp_we(b_rwe),
        .resp_misalign(b_mis), .mem_req(b_mreq), .mem_gnt(mem_gnt && use64),
        .mem_we(b_mwe), .mem_addr(b_maddr), .mem_be(b_mbe), .mem_wdata(b_mwdata),
        .mem_rvalid(mem_rvalid && use64), .mem_rdata(mem_rdata)
    );

    wire        o_ready = use64 ? b_ready : a_ready;
    wire        o_rv    = use64 ? b_rv    : a_rv;
    wire        o_rwe   = use64 ? b_rwe   : a_rwe;
    wire        o_mis   = use64 ? b_mis   : a_mis;
    wire        o_mreq  = use64 ? b_mreq  : a_mreq;
    wire        o_mwe   = use64 ? b_mwe   : a_mwe;
    wire [4:0]  o_rd    = use64 ? b_rd    : a_rd;
    wire [31:0] o_maddr = use64 ? b_maddr : a_maddr;
    wire [7:0]  o_mbe   = use64 ? b_mbe   : {4'h0, a_mbe};
    wire [63:0] o_rdata = use64 ? b_rdata : {32'h0, a_rdata};
    wire [63:0] o_mwd   = use64 ? b_mwdata : {32'h0, a_mwdata};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] m_mask(input int bits);
        return (bits >= 64) ? {64{1'b1}} : ((64'd1 << bits) - 64'd1);
    endfunction

    function automatic bit m_illegal(input int datw, input logic [1:0] sz, input logic [31:0] addr);
        int n = 1 << sz;
        return (n * 8 > datw) || ((addr % n) != 0);
    endfunction

    function automatic logic [63:0] m_be(input int datw, input logic [1:0] sz, input logic [31:0] addr);
        int lanes = datw / 8;
        int l = int'(addr % lanes);
        int n = 1 << sz;
        logic [63:0] be = 64'h0;
        for (int j = l; j < l + n; j++) be[BIGE ? (lanes - 1 - j) : j] = 1'b1;
        return be;
    endfunction

    function automatic logic [63:0] m_wdata(input int datw, input logic [1:0] sz, input logic [63:0] wd);
        int n = 1 << sz;
        logic [63:0] val = wd & m_mask(8 * n);
        logic [63:0] r = 64'h0;
        for (int k = 0; k < datw / (8 * n); k++) r = r | (val << (8 * n * k));
        return r;
    endfunction

    // Memory bytes by address offset, then reassembled in memory byte order and extended
    function automatic logic [63:0] m_load(input int datw, input logic [1:0] sz, input bit uns,
                                           input logic [31:0] addr, input logic [63:0] rdata);
        int lanes = datw / 8;
        int l = int'(addr % lanes);
        int n = 1 << sz;
        logic [7:0] bytes [8];
        logic [63:0] v = 64'h0;
        for (int j = 0; j < lanes; j++)
            bytes[j] = BIGE ? 8'(rdata >> (datw - 8 - 8 * j)) : 8'(rdata >> (8 * j));
        for (int i = 0; i < n; i++)
            v = BIGE ? ((v << 8) | 64'(bytes[l + i])) : (v | (64'(bytes[l + i]) << (8 * i)));
        if (!uns && v[8 * n - 1]) v = v | ~m_mask(8 * n);
        return v & m_mask(datw);
    endfunction

    task automatic start(input bit we, input logic [1:0] sz, input logic [31:0] addr);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = 1'b0;
        req_addr = addr; req_wdata = {$urandom, $urandom}; req_rd = 5'd1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic access(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                          input logic [63:0] wd, input logic [4:0] rd, input int gd, input int rvd,
                          input logic [63:0] rdat);
        int datw = use64 ? 64 : 32;
        int lanes = datw / 8;
        bit ill = m_illegal(datw, sz, addr);
        logic [63:0] exp_wd = m_wdata(datw, sz, wd);
        chk("ready_idle", o_ready, 1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_rd = rd;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = {$urandom, $urandom}; req_rd = 5'($urandom);
        if (ill) begin
            chk("flt_valid", o_rv, 1);
            chk("flt_misalign", o_mis, 1);
            chk("flt_rdata", o_rdata, 0);
            chk("flt_we", o_rwe, 0);
            chk("flt_memreq", o_mreq, 0);
            chk("flt_ready", o_ready, 0);
            @(negedge clk);
            chk("flt_pulse", o_rv, 0);
            return;
        end
        for (int c = 0; c <= gd; c++) begin
            chk("iss_memreq", o_mreq, 1);
            chk("iss_memwe", o_mwe, we);
            chk("iss_addr", o_maddr, addr - (addr % lanes));
            chk("iss_be", o_mbe, m_be(datw, sz, addr));
            if (we) chk("iss_wdata", o_mwd, exp_wd);
            chk("iss_ready", o_ready, 0);
            chk("iss_resp", o_rv, 0);
            mem_gnt = (c == gd);
            mem_rvalid = 1'($urandom);
            @(negedge clk);
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        if (!we) begin
            for (int k = 1; k <= rvd; k++) begin
                chk("wait_memreq", o_mreq, 0);
                chk("wait_resp", o_rv, 0);
                chk("wait_ready", o_ready, 0);
                mem_rvalid = (k == rvd);
                mem_gnt = 1'($urandom);
                mem_rdata = (k == rvd) ? rdat : {$urandom, $urandom};
                @(negedge clk);
            end
            mem_rvalid = 1'b0;
            mem_gnt = 1'b0;
        end
        chk("resp_valid", o_rv, 1);
        chk("resp_memreq", o_mreq, 0);
        chk("resp_misalign", o_mis, 0);
        chk("resp_we", o_rwe, !we);
        chk("resp_rdata", o_rdata, we ? 64'h0 : m_load(datw, sz, uns, addr, rdat));
        if (!we) chk("resp_rd", o_rd, rd);
        chk("resp_ready", o_ready, 0);
        @(negedge clk);
        chk("resp_pulse", o_rv, 0);
    endtask

    initial begin
        #1 rst = 1'b0;
        #11;
        chk("rst_memreq", o_mreq, 0);
        chk("rst_resp", o_rv, 0);
        chk("rst_be", o_mbe, 0);
        chk("rst_addr", o_maddr, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", o_ready, 1);

        access(1'b1, 2'b00, 1'b0, 32'h1001, 64'hAB, 5'd0, 0, 0, 64'h0);
        access(1'b0, 2'b00, 1'b0, 32'h1003, 64'h0, 5'd7, 0, 1, 64'h12345680);
        access(1'b0, 2'b00, 1'b1, 32'h1003, 64'h0, 5'd8, 1, 1, 64'h12345680);
        access(1'b0, 2'b01, 1'b0, 32'h1002, 64'h0, 5'd9, 0, 2, 64'h12345680);
        access(1'b0, 2'b01, 1'b0, 32'h1001, 64'h0, 5'd10, 0, 1, 64'h0);
        access(1'b0, 2'b11, 1'b0, 32'h1000, 64'h0, 5'd11, 0, 1, 64'h0);
        access(1'b0, 2'b10, 1'b0, 32'h1004, 64'h0, 5'd12, 3, 2, 64'hCAFEF00D);

        // Reset while the request is outstanding: mem_req drops at once
        start(1'b0, 2'b10, 32'h1008);
        chk("rsti_memreq_pre", o_mreq, 1);
        #2 rst = 1'b0;
        #1 chk("rsti_memreq", o_mreq, 0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) chk("rsti_ready", o_ready, 1);

        // Reset during the response pulse clears resp_valid at once
        start(1'b1, 2'b00, 32'h100C);
        mem_gnt = 1'b1;
        @(negedge clk) mem_gnt = 1'b0;
        chk("rstd_resp_pre", o_rv, 1);
        #2 rst = 1'b0;
        #1 chk("rstd_resp", o_rv, 0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);

        // Reset while waiting for load data; the late rvalid is ignored
        start(1'b0, 2'b10, 32'h1010);
        mem_gnt = 1'b1;
        @(negedge clk) mem_gnt = 1'b0;
        #2 rst = 1'b0;
        #1 chk("rstw_resp", o_rv, 0);
        chk("rstw_memreq", o_mreq, 0);
        @(negedge clk) rst = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 64'h55AA55AA;
        @(negedge clk) mem_rvalid = 1'b0;
        chk("rstw_stray", o_rv, 0);
        access(1'b0, 2'b10, 1'b0, 32'h1014, 64'h0, 5'd13, 1, 1, 64'h89ABCDEF);

        use64 = 1'b1;
        @(negedge clk);
        access(1'b1, 2'b10, 1'b0, 32'h2004, 64'hDEADBEEF, 5'd0, 0, 0, 64'h0);
        access(1'b0, 2'b11, 1'b0, 32'h2000, 64'h0, 5'd3, 1, 1, 64'hF123456789ABCDEF);
        access(1'b0, 2'b11, 1'b0, 32'h2004, 64'h0, 5'd4, 0, 1, 64'h0);

        for (int it = 0; it < 200; it++) begin
            use64 = 1'($urandom);
            @(negedge clk);
            r_we = 1'($urandom); r_uns = 1'($urandom); r_sz = 2'($urandom);
            r_addr = 32'h3000 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~((32'd1 << r_sz) - 32'd1);
            r_wd = {$urandom, $urandom}; r_rdat = {$urandom, $urandom}; r_rd = 5'($urandom);
            r_gd = $urandom_range(0, 3); r_rvd = $urandom_range(1, 3);
            access(r_we, r_sz, r_uns, r_addr, r_wd, r_rd, r_gd, r_rvd, r_rdat);
            if (it % 4 == 0) begin
                mem_gnt = 1'b1; mem_rvalid = 1'b1;
                @(negedge clk);
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
                chk("stray_resp", o_rv, 0);
                chk("stray_memreq", o_mreq, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
